// File: rtl/sram_like_pkg.sv
// sram_like_pkg: size encodings, arbiter FSM states and ID width helper
// shared by sram_like_arbiter and resp_id_fifo.
package sram_like_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/resp_id_fifo.sv
// resp_id_fifo: synchronous in-order FIFO of master IDs awaiting data_ok.
module resp_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [PW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full    = cnt_q == (PW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign head    = mem_q[rd_q];
    assign do_push = push & ~full;
    // A pop against an empty queue is dropped so the count cannot underflow.
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges N SRAM-like masters onto one slave port with in-order response routing.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (index 0 highest) otherwise.
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int N_MASTERS       = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [N_MASTERS-1:0]            m_req,
    input  logic [N_MASTERS-1:0]            m_wr,
    input  logic [2*N_MASTERS-1:0]          m_size,
    input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
    output logic [N_MASTERS-1:0]            m_addr_ok,
    output logic [N_MASTERS-1:0]            m_data_ok,
    output logic [DATA_W-1:0]               m_rdata,
    output logic                            s_req,
    output logic                            s_wr,
    output logic [1:0]                      s_size,
    output logic [DATA_W/8-1:0]             s_wstrb,
    output logic [ADDR_W-1:0]               s_addr,
    output logic [DATA_W-1:0]               s_wdata,
    input  logic                            s_addr_ok,
    input  logic                            s_data_ok,
    input  logic [DATA_W-1:0]               s_rdata
);
    localparam int ID_W = id_width(N_MASTERS);
    localparam int SW   = DATA_W / 8;

    arb_state_e      state_q;
    logic [ID_W-1:0] lock_q, arb_idx, grant, head;
    logic            full, empty, hs;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_q;
    logic            found;
    always_comb begin
        arb_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (!found && m_req[(int'(rr_q) + k) % N_MASTERS]) begin
                arb_idx = ID_W'((int'(rr_q) + k) % N_MASTERS);
                found   = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!resetn) rr_q <= '0;
        else if (hs) rr_q <= (grant == ID_W'(N_MASTERS - 1)) ? '0 : grant + 1'b1;
    end
`else
    always_comb begin
        arb_idx = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (m_req[i]) arb_idx = ID_W'(i);
        end
    end
`endif

    // Once offered, a request is held on the same master until the slave accepts it.
    assign grant = (state_q == ARB_LOCKED) ? lock_q : arb_idx;
    assign s_req = resetn & ~full & ((state_q == ARB_LOCKED) | (|m_req));
    assign hs    = s_req & s_addr_ok;

    assign s_wr    = s_req & m_wr[grant];
    assign s_size  = s_req ? m_size[grant*2 +: 2] : '0;
    assign s_wstrb = s_req ? m_wstrb[grant*SW +: SW] : '0;
    assign s_addr  = s_req ? m_addr[grant*ADDR_W +: ADDR_W] : '0;
    assign s_wdata = s_req ? m_wdata[grant*DATA_W +: DATA_W] : '0;

    assign m_addr_ok = hs ? (N_MASTERS'(1) << grant) : '0;
    assign m_data_ok = (resetn & s_data_ok & ~empty) ? (N_MASTERS'(1) << head) : '0;
    assign m_rdata   = s_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
            lock_q  <= '0;
        end else begin
            state_q <= (s_req & ~s_addr_ok) ? ARB_LOCKED : ARB_IDLE;
            lock_q  <= grant;
        end
    end

    resp_id_fifo #(.DEPTH(MAX_OUTSTANDING), .W(ID_W)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (hs),
        .pop    (s_data_ok),
        .din    (grant),
        .full   (full),
        .empty  (empty),
        .head   (head)
    );
endmodule
